ram1_arbiter: RTL and testbench

//  Owns the shared RAM1/COM1 bus and multiplexes it between instruction fetch (IF port) and data access (MEM port).

---
 rtl/ram1_arbiter_pkg.sv | 39 +++
 rtl/ram1_arbiter_addr_decode.sv | 27 ++
 rtl/ram1_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_ram1_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram1_arbiter_pkg.sv
// ============================================================================
// Module  : ram1_arbiter_pkg
// Brief   : Shared constants, FSM state codes and helpers for the RAM1 arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ram1_arbiter_pkg;

    localparam logic [15:0] c_ram1_upper = 16'h8000;
    localparam logic [15:0] c_com1_data  = 16'hBF00;
    localparam logic [15:0] c_com1_cmd   = 16'hBF01;
    localparam logic [15:0] c_nop_word   = 16'h0800;

    localparam int          c_st_w          = 4;
    localparam logic [3:0]  c_st_idle       = 4'd0;
    localparam logic [3:0]  c_st_rd_setup   = 4'd1;
    localparam logic [3:0]  c_st_rd_sample  = 4'd2;
    localparam logic [3:0]  c_st_wr_setup   = 4'd3;
    localparam logic [3:0]  c_st_wr_strobe  = 4'd4;
    localparam logic [3:0]  c_st_wr_hold    = 4'd5;
    localparam logic [3:0]  c_st_u_rd       = 4'd6;
    localparam logic [3:0]  c_st_u_rd_smp   = 4'd7;
    localparam logic [3:0]  c_st_u_wr       = 4'd8;
    localparam logic [3:0]  c_st_u_wr_hold  = 4'd9;
    localparam logic [3:0]  c_st_status     = 4'd10;

    // SRAM read states are shared with IF, so ownership decides whether they count as MEM.
    function automatic logic f_is_mem_state(input logic [3:0] st, input logic owner_mem);
        case (st)
            c_st_idle:                     return 1'b0;
            c_st_rd_setup, c_st_rd_sample: return owner_mem;
            default:                       return 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram1_arbiter_addr_decode.sv
// ============================================================================
// Module  : ram1_arbiter_addr_decode
// Brief   : Combinational MEM address decode into SRAM / UART data / UART status.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram1_arbiter_addr_decode
    import ram1_arbiter_pkg::*;
#(
    parameter logic [15:0] RAM1_UPPER = c_ram1_upper,
    parameter logic [15:0] COM1_DATA  = c_com1_data,
    parameter logic [15:0] COM1_CMD   = c_com1_cmd
) (
    input  logic [15:0] mem_addr,
    output logic        is_sram,
    output logic        is_udata,
    output logic        is_ustat
);

    assign is_sram  = (mem_addr < RAM1_UPPER);
    assign is_udata = (mem_addr == COM1_DATA);
    assign is_ustat = (mem_addr == COM1_CMD);

endmodule

`default_nettype wire

// File: rtl/ram1_arbiter.sv
// ============================================================================
// Module  : ram1_arbiter
// Brief   : Arbitrates the RAM1/COM1 bus between IF fetch and MEM data access,
//           sequencing SRAM and UART cycles. Define ARB_FAIR_EN for alternating
//           MEM/IF grants; otherwise MEM has strict priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram1_arbiter
    import ram1_arbiter_pkg::*;
#(
    parameter logic [15:0] RAM1_UPPER = c_ram1_upper,
    parameter logic [15:0] COM1_DATA  = c_com1_data,
    parameter logic [15:0] COM1_CMD   = c_com1_cmd,
    parameter logic [15:0] NOP_WORD   = c_nop_word
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_done,
    output logic [17:0] ram1_addr,
    inout  wire  [15:0] ram1_data,
    output logic        ram1_en,
    output logic        ram1_oe,
    output logic        ram1_we,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_dready,
    input  logic        uart_tbre,
    input  logic        uart_tsre
);

    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_next_state;
    logic [15:0]       r_addr;
    logic [15:0]       r_wdata;
    logic              r_owner_mem;
    logic              r_if_valid;
    logic [15:0]       r_if_rdata;
    logic              r_mem_done;
    logic [15:0]       r_mem_rdata;

    logic w_is_sram;
    logic w_is_udata;
    logic w_is_ustat;
    logic w_mem_claim;
    logic w_arb;
    logic w_if_first;
    logic w_grant_mem;
    logic w_grant_if;
    logic w_drive;

    ram1_arbiter_addr_decode #(
        .RAM1_UPPER (RAM1_UPPER),
        .COM1_DATA  (COM1_DATA),
        .COM1_CMD   (COM1_CMD)
    ) u_decode (
        .mem_addr (mem_addr),
        .is_sram  (w_is_sram),
        .is_udata (w_is_udata),
        .is_ustat (w_is_ustat)
    );

    assign w_mem_claim = (mem_rd | mem_wr) & (w_is_sram | w_is_udata | w_is_ustat);

    // The IDLE cycle carrying a completion pulse grants nothing: the finishing
    // requester's level is still up and must not be re-sampled as a new request.
    assign w_arb = (r_state == c_st_idle) & ~r_if_valid & ~r_mem_done;

`ifdef ARB_FAIR_EN
    logic r_last_mem;

    assign w_if_first = r_last_mem & if_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_mem <= 1'b0;
        end else if (w_grant_mem) begin
            r_last_mem <= 1'b1;
        end else if (w_grant_if) begin
            r_last_mem <= 1'b0;
        end
    end
`else
    assign w_if_first = 1'b0;
`endif

    assign w_grant_mem = w_arb & w_mem_claim & ~w_if_first;
    assign w_grant_if  = w_arb & if_req & ~w_grant_mem;

    assign if_stall = f_is_mem_state(r_state, r_owner_mem)
                    | (w_mem_claim & ~r_mem_done & ~w_if_first);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_grant_mem) begin
                    if (w_is_sram) begin
                        w_next_state = mem_wr ? c_st_wr_setup : c_st_rd_setup;
                    end else if (w_is_udata) begin
                        w_next_state = mem_wr ? c_st_u_wr : c_st_u_rd;
                    end else begin
                        w_next_state = c_st_status;
                    end
                end else if (w_grant_if) begin
                    w_next_state = c_st_rd_setup;
                end
            end
            c_st_rd_setup:  w_next_state = c_st_rd_sample;
            c_st_rd_sample: w_next_state = c_st_idle;
            c_st_wr_setup:  w_next_state = c_st_wr_strobe;
            c_st_wr_strobe: w_next_state = c_st_wr_hold;
            c_st_wr_hold:   w_next_state = c_st_idle;
            c_st_u_rd:      w_next_state = c_st_u_rd_smp;
            c_st_u_rd_smp:  w_next_state = c_st_idle;
            c_st_u_wr:      w_next_state = c_st_u_wr_hold;
            c_st_u_wr_hold: w_next_state = c_st_idle;
            c_st_status:    w_next_state = c_st_idle;
            default:        w_next_state = c_st_idle;
        endcase
    end

    // Bus strobes decode straight from state so an async reset releases them at once.
    always_comb begin
        ram1_en  = 1'b1;
        ram1_oe  = 1'b1;
        ram1_we  = 1'b1;
        uart_rdn = 1'b1;
        uart_wrn = 1'b1;
        w_drive  = 1'b0;
        case (r_state)
            c_st_rd_setup, c_st_rd_sample: begin
                ram1_en = 1'b0;
                ram1_oe = 1'b0;
            end
            c_st_wr_setup, c_st_wr_hold: begin
                ram1_en = 1'b0;
                w_drive = 1'b1;
            end
            c_st_wr_strobe: begin
                ram1_en = 1'b0;
                ram1_we = 1'b0;
                w_drive = 1'b1;
            end
            c_st_u_rd: begin
                uart_rdn = 1'b0;
            end
            c_st_u_wr: begin
                uart_wrn = 1'b0;
                w_drive  = 1'b1;
            end
            c_st_u_wr_hold: begin
                w_drive = 1'b1;
            end
            default: begin
                w_drive = 1'b0;
            end
        endcase
    end

    // Latched request and completion datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_owner_mem <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_rdata  <= NOP_WORD;
            r_mem_done  <= 1'b0;
            r_mem_rdata <= 16'h0000;
        end else begin
            r_if_valid <= 1'b0;
            r_mem_done <= 1'b0;
            r_if_rdata <= NOP_WORD;
            if (w_grant_mem) begin
                r_addr      <= mem_addr;
                r_wdata     <= mem_wdata;
                r_owner_mem <= 1'b1;
            end else if (w_grant_if) begin
                r_addr      <= if_addr;
                r_owner_mem <= 1'b0;
            end
            case (r_state)
                c_st_rd_sample: begin
                    if (r_owner_mem) begin
                        r_mem_rdata <= ram1_data;
                        r_mem_done  <= 1'b1;
                    end else begin
                        r_if_rdata <= ram1_data;
                        r_if_valid <= 1'b1;
                    end
                end
                c_st_wr_hold, c_st_u_wr_hold, c_st_u_rd_smp: begin
                    r_mem_done <= 1'b1;
                end
                c_st_u_rd: begin
                    // Capture while rdn is still low; the UART may release the bus once it rises.
                    r_mem_rdata <= ram1_data;
                end
                c_st_status: begin
                    r_mem_rdata <= {14'b0, uart_dready, uart_tbre & uart_tsre};
                    r_mem_done  <= 1'b1;
                end
                default: begin
                    r_mem_done <= 1'b0;
                end
            endcase
        end
    end

    assign ram1_data = w_drive ? r_wdata : 16'hzzzz;
    assign ram1_addr = {2'b00, r_addr};
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign mem_rdata = r_mem_rdata;
    assign mem_done  = r_mem_done;

endmodule

`default_nettype wire

// File: tb/tb_ram1_arbiter.sv
// ============================================================================
// Module  : tb_ram1_arbiter
// Brief   : Self-checking bench for ram1_arbiter with SRAM/UART pin models and
//           a word-level reference memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram1_arbiter;

    localparam logic [15:0] NOP      = 16'h0800;
    localparam logic [15:0] UDATA    = 16'hBF00;
    localparam logic [15:0] USTAT    = 16'hBF01;
    localparam int          LAT_RD   = 4;
    localparam int          LAT_WR   = 5;
    localparam int          LAT_UART = 4;
    localparam int          LAT_STAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [15:0] mem_addr = 16'h0;
    logic [15:0] mem_wdata = 16'h0;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic [17:0] ram1_addr;
    wire  [15:0] ram1_data;
    logic        ram1_en, ram1_oe, ram1_we, uart_rdn, uart_wrn;
    logic        uart_dready = 1'b0;
    logic        uart_tbre = 1'b0;
    logic        uart_tsre = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    // Board models: SRAM device and UART receive register
    logic [15:0] dev_sram [0:32767];
    bit          dev_valid [0:32767];
    logic [15:0] uart_rx = 16'h0;
    logic        bus_en;
    logic [15:0] bus_val;
    logic [15:0] ref_mem [0:32767];

    int          n_oe = 0, n_we = 0, n_en = 0, n_wrn = 0, n_done = 0, n_valid = 0, n_drv = 0;
    logic [15:0] exp_drive = 16'h0;
    logic [15:0] last_tx = 16'h0;

    always #5 clk = ~clk;

    ram1_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram1_addr(ram1_addr), .ram1_data(ram1_data),
        .ram1_en(ram1_en), .ram1_oe(ram1_oe), .ram1_we(ram1_we),
        .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
        .uart_dready(uart_dready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
    );

    function automatic logic [15:0] dflt(input logic [14:0] a);
        return {1'b0, a} ^ 16'h5A3C;
    endfunction

    always_comb begin
        bus_en  = (!ram1_en && !ram1_oe) || !uart_rdn;
        bus_val = !uart_rdn ? uart_rx
                : (dev_valid[ram1_addr[14:0]] ? dev_sram[ram1_addr[14:0]] : dflt(ram1_addr[14:0]));
    end
    assign ram1_data = bus_en ? bus_val : 16'hzzzz;

    always @(negedge clk) begin
        if (!ram1_en && !ram1_we) begin
            dev_sram[ram1_addr[14:0]]  <= ram1_data;
            dev_valid[ram1_addr[14:0]] <= 1'b1;
        end
        if (!uart_wrn) begin
            last_tx <= ram1_data;
            n_wrn   <= n_wrn + 1;
        end
        if (!ram1_oe)  n_oe    <= n_oe + 1;
        if (!ram1_we)  n_we    <= n_we + 1;
        if (!ram1_en)  n_en    <= n_en + 1;
        if (mem_done)  n_done  <= n_done + 1;
        if (if_valid)  n_valid <= n_valid + 1;
        if (!bus_en && ram1_data === exp_drive) n_drv <= n_drv + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One MEM access; address/data are scrambled mid-access to prove they were latched.
    task automatic mem_op(input logic wr, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
        lat = -1;
        rd  = 16'h0;
        mem_rd = !wr; mem_wr = wr; mem_addr = a; mem_wdata = d;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) begin
                mem_addr  = a ^ 16'h0001;
                mem_wdata = ~d;
            end
            if (mem_done) begin
                lat = k;
                rd  = mem_rdata;
                break;
            end
        end
        tick();
        mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a, output logic [15:0] rd, output int lat);
        lat = -1;
        rd  = 16'h0;
        if_req = 1'b1; if_addr = a;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (if_valid) begin
                lat = k;
                rd  = if_rdata;
                break;
            end
        end
        tick();
        if_req = 1'b0;
    endtask

    initial begin
        logic [15:0] rd, a, d, mrd, ird;
        int          lat, s0, s1, s2, md, iv, sbad, nbad, op, dd, dv;

        for (int i = 0; i < 32768; i++) ref_mem[i] = dflt(15'(i));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en",    {31'b0, ram1_en}, 1);
        chk("rst_oe",    {31'b0, ram1_oe}, 1);
        chk("rst_we",    {31'b0, ram1_we}, 1);
        chk("rst_rdn",   {31'b0, uart_rdn}, 1);
        chk("rst_wrn",   {31'b0, uart_wrn}, 1);
        chk("rst_addr",  {14'b0, ram1_addr}, 0);
        chk("rst_flags", {29'b0, if_valid, mem_done, if_stall}, 0);
        chk("rst_ifrd",  {16'b0, if_rdata}, {16'b0, NOP});
        chk("rst_memrd", {16'b0, mem_rdata}, 0);
        rst = 1'b1;
        tick();

        // Seed the fetch word, then fetch it
        mem_op(1'b1, 16'h0004, 16'h6801, rd, lat);
        ref_mem[4] = 16'h6801;
        chk("wr4_lat", lat, LAT_WR);
        s0 = n_oe;
        fetch(16'h0004, rd, lat);
        chk("fetch_data", {16'b0, rd}, {16'b0, ref_mem[4]});
        chk("fetch_lat",  lat, LAT_RD);
        chk("fetch_oe2",  n_oe - s0, 2);

        // Simultaneous IF and MEM: MEM first
        md = -1; iv = -1; sbad = 0; nbad = 0; mrd = 0; ird = 0;
        mem_rd = 1'b1; mem_addr = 16'h0010; if_req = 1'b1; if_addr = 16'h0004;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (mem_done && md < 0) begin md = k; mrd = mem_rdata; end
            if (md < 0 && !if_stall) sbad++;
            if (!if_valid && if_rdata !== NOP) nbad++;
            if (if_valid && iv < 0) begin iv = k; ird = if_rdata; end
            tick();
            if (md > 0) mem_rd = 1'b0;
            if (iv > 0) begin if_req = 1'b0; break; end
        end
        if_req = 1'b0; mem_rd = 1'b0;
        chk("conc_mem_lat",  md, LAT_RD);
        chk("conc_if_lat",   iv, LAT_RD + LAT_RD);
        chk("conc_mem_data", {16'b0, mrd}, {16'b0, ref_mem[16]});
        chk("conc_if_data",  {16'b0, ird}, 16'h6801);
        chk("conc_stall",    sbad, 0);
        chk("conc_nop",      nbad, 0);

        // SRAM write pin sequence
        exp_drive = 16'hA5A5;
        s0 = n_we; s1 = n_drv; s2 = n_done;
        mem_op(1'b1, 16'h0020, 16'hA5A5, rd, lat);
        ref_mem[16'h20] = 16'hA5A5;
        tick(); tick();
        chk("wr_lat",   lat, LAT_WR);
        chk("wr_we1",   n_we - s0, 1);
        chk("wr_drv3",  n_drv - s1, 3);
        chk("wr_done1", n_done - s2, 1);
        chk("wr_sram",  {16'b0, dev_sram[16'h20]}, 16'hA5A5);
        mem_op(1'b0, 16'h0020, 16'h0, rd, lat);
        chk("wr_readback", {16'b0, rd}, 16'hA5A5);

        // UART status and data
        uart_dready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b1;
        mem_op(1'b0, USTAT, 16'h0, rd, lat);
        chk("stat_data", {16'b0, rd}, 16'h0003);
        chk("stat_lat",  lat, LAT_STAT);
        s0 = n_wrn; s1 = n_en;
        mem_op(1'b1, UDATA, 16'h0041, rd, lat);
        chk("utx_lat",  lat, LAT_UART);
        chk("utx_wrn1", n_wrn - s0, 1);
        chk("utx_en0",  n_en - s1, 0);
        chk("utx_data", {16'b0, last_tx}, 16'h0041);
        uart_rx = 16'(($urandom % 256));
        mem_op(1'b0, UDATA, 16'h0, rd, lat);
        chk("urx_data", {16'b0, rd}, {16'b0, uart_rx});
        chk("urx_lat",  lat, LAT_UART);

        // Unmapped address: ignored entirely
        s0 = n_done; sbad = 0;
        mem_rd = 1'b1; mem_addr = 16'hC000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if_stall) sbad++;
        end
        tick();
        mem_rd = 1'b0;
        chk("unmap_done",  n_done - s0, 0);
        chk("unmap_stall", sbad, 0);

        // Randomised traffic against the reference memory
        for (int i = 0; i < 24; i++) begin
            op = int'($urandom_range(0, 4));
            a  = 16'h0100 + 16'($urandom_range(0, 15));
            d  = 16'($urandom);
            case (op)
                0: begin
                    mem_op(1'b1, a, d, rd, lat);
                    ref_mem[a[14:0]] = d;
                    chk("rnd_wr_lat", lat, LAT_WR);
                end
                1: begin
                    mem_op(1'b0, a, 16'h0, rd, lat);
                    chk("rnd_rd", {16'b0, rd}, {16'b0, ref_mem[a[14:0]]});
                end
                2: begin
                    fetch(a, rd, lat);
                    chk("rnd_fetch", {16'b0, rd}, {16'b0, ref_mem[a[14:0]]});
                end
                3: begin
                    uart_dready = 1'($urandom); uart_tbre = 1'($urandom); uart_tsre = 1'($urandom);
                    mem_op(1'b0, USTAT, 16'h0, rd, lat);
                    chk("rnd_stat", {16'b0, rd}, {30'b0, uart_dready, uart_tbre && uart_tsre});
                end
                default: begin
                    mem_op(1'b1, UDATA, d, rd, lat);
                    chk("rnd_utx", {16'b0, last_tx}, {16'b0, d});
                end
            endcase
        end

        // MEM held continuously alongside IF
        s0 = n_done; s1 = n_valid;
        mem_rd = 1'b1; mem_addr = 16'h0100; if_req = 1'b1; if_addr = 16'h0104;
        repeat (40) @(posedge clk);
        #1;
        dd = n_done - s0; dv = n_valid - s1;
        mem_rd = 1'b0; if_req = 1'b0;
        repeat (10) tick();
`ifdef ARB_FAIR_EN
        chk("fair_if",   {31'b0, dv >= 4}, 1);
        chk("fair_mem",  {31'b0, dd >= 4}, 1);
        chk("fair_bal",  {31'b0, (dd - dv) <= 1 && (dv - dd) <= 1}, 1);
`else
        chk("strict_if",  dv, 0);
        chk("strict_mem", {31'b0, dd >= 9}, 1);
`endif

        // Reset asserted during the write strobe
        s0 = n_done; md = 0;
        mem_wr = 1'b1; mem_addr = 16'h0030; mem_wdata = 16'h1234;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!ram1_we) begin md = 1; break; end
        end
        chk("abort_seen", md, 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_we",  {31'b0, ram1_we}, 1);
        chk("abort_en",  {31'b0, ram1_en}, 1);
        chk("abort_oe",  {31'b0, ram1_oe}, 1);
        chk("abort_bus", {31'b0, ram1_data !== 16'h1234}, 1);
        mem_wr = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("abort_nodone", n_done - s0, 0);
        fetch(16'h0004, rd, lat);
        chk("post_rst_fetch", {16'b0, rd}, 16'h6801);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
